// File: rtl/pc_pkg.sv
// pc_pkg: shared types and defaults for the fetch-stage PC unit.
//   state_e      - control FSM states
//   redir_src_e  - redirect source, with fixed branch-over-jump priority
//   RESET_VECTOR_DEF / STEP_DEF - default reset PC and sequential step
package pc_pkg;

   typedef enum logic [1:0] {IDLE, RUN, WAIT} state_e;

   typedef enum logic [1:0] {SRC_NONE, SRC_JUMP, SRC_BRANCH} redir_src_e;

   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam int unsigned STEP_DEF         = 4;

   // The branch comes from the older instruction (execute), so it wins.
   function automatic redir_src_e redirect_sel(input logic branch, input logic jump);
      if (branch) return SRC_BRANCH;
      if (jump)   return SRC_JUMP;
      return SRC_NONE;
   endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: instruction-fetch request channel (valid/ready).
//   imem_req_valid - fetch request valid (master -> slave)
//   imem_req_addr  - fetch address       (master -> slave)
//   imem_req_ready - slave accepts       (slave -> master)
interface pc_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            imem_req_valid;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_req_ready;

   modport master (output imem_req_valid, output imem_req_addr, input imem_req_ready);
   modport slave  (input imem_req_valid, input imem_req_addr, output imem_req_ready);
endinterface

// File: rtl/pc_history.sv
// pc_history: shift register of accepted fetch addresses.
//   clk     - clock
//   clr_i   - synchronous clear to zero
//   shift_i - shift enable (one accepted address)
//   din_i   - address entering slot 0
//   hist_o  - history, slot 0 most recent
module pc_history #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned HIST_DEPTH = 2
) (
   input  logic                             clk,
   input  logic                             clr_i,
   input  logic                             shift_i,
   input  logic [XLEN-1:0]                  din_i,
   output logic [HIST_DEPTH-1:0][XLEN-1:0]  hist_o
);

   logic [HIST_DEPTH-1:0][XLEN-1:0] hist_q;

   always_ff @(posedge clk) begin
      if (clr_i) begin
         hist_q <= '0;
      end else if (shift_i) begin
         hist_q[0] <= din_i;
         for (int i = 1; i < HIST_DEPTH; i++) hist_q[i] <= hist_q[i-1];
      end
   end

   assign hist_o = hist_q;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter.
//   clk, rst            - clock, synchronous active-high reset
//   stall               - back-end stall, suppresses new requests
//   branch_taken/target - execute-stage redirect (highest priority)
//   jump_valid/target   - decode-stage redirect
//   imem                - fetch request channel (master side)
//   pc_out              - current PC (also the request address)
//   pc_hist             - accepted-address history, slice 0 most recent
//   redirect_pending    - a redirect is buffered behind a held request
//   target_misalign     - pulse: the applied target had bits [1:0] set
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
   parameter int unsigned     STEP         = STEP_DEF,
   parameter int unsigned     HIST_DEPTH   = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic                       branch_taken,
   input  logic [XLEN-1:0]            branch_target,
   input  logic                       jump_valid,
   input  logic [XLEN-1:0]            jump_target,
   pc_unit_if.master                  imem,
   output logic [XLEN-1:0]            pc_out,
   output logic [HIST_DEPTH*XLEN-1:0] pc_hist,
   output logic                       redirect_pending,
   output logic                       target_misalign
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
   logic            pend_vld_q, pend_vld_d;
   logic            mis_q, mis_d;

   redir_src_e      src;
   logic [XLEN-1:0] live_tgt, raw_tgt;
   logic            req_valid, hs, apply;
   logic [HIST_DEPTH-1:0][XLEN-1:0] hist;

   assign src      = redirect_sel(branch_taken, jump_valid);
   assign live_tgt = (src == SRC_BRANCH) ? branch_target : jump_target;

   // Once raised (WAIT), the request stays up even if stall asserts.
   always_comb begin
      req_valid = 1'b0;
      case (state_q)
         RUN:     req_valid = !stall;
         WAIT:    req_valid = 1'b1;
         default: req_valid = 1'b0;
      endcase
   end

   assign hs = req_valid & imem.imem_req_ready;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_tgt_d = pend_tgt_q;
      pend_vld_d = pend_vld_q;
      raw_tgt    = live_tgt;
      apply      = 1'b0;

      case (state_q)
         IDLE:    state_d = RUN;
         RUN:     if (req_valid && !imem.imem_req_ready) state_d = WAIT;
         WAIT:    if (imem.imem_req_ready) state_d = RUN;
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE) begin
         if (!req_valid || hs) begin
            // PC is free to move: live redirect, then buffered one, then step.
            if (src != SRC_NONE) begin
               apply      = 1'b1;
               pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
               apply      = 1'b1;
               raw_tgt    = pend_tgt_q;
               pend_vld_d = 1'b0;
            end else if (hs) begin
               pc_d = pc_q + XLEN'(STEP);
            end
         end else if (src != SRC_NONE) begin
            // Address is held on the bus; newest redirect replaces any older one.
            pend_tgt_d = live_tgt;
            pend_vld_d = 1'b1;
         end
      end

      if (apply) pc_d = {raw_tgt[XLEN-1:2], 2'b00};
      mis_d = apply & (raw_tgt[1:0] != 2'b00);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= RESET_VECTOR;
         pend_tgt_q <= '0;
         pend_vld_q <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_tgt_q <= pend_tgt_d;
         pend_vld_q <= pend_vld_d;
         mis_q      <= mis_d;
      end
   end

   pc_history #(.XLEN(XLEN), .HIST_DEPTH(HIST_DEPTH)) u_hist (
      .clk     (clk),
      .clr_i   (rst),
      .shift_i (hs),
      .din_i   (pc_q),
      .hist_o  (hist)
   );

   assign imem.imem_req_valid = req_valid;
   assign imem.imem_req_addr  = pc_q;
   assign pc_out              = pc_q;
   assign pc_hist             = hist;
   assign redirect_pending    = pend_vld_q;
   assign target_misalign     = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed + short random stimulus; a cycle-level model of the
// fetch rules is compared against the DUT every cycle, and literal checks
// pin the walkthrough scenarios (including a wrapping reset vector).
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst, stall, br, jv, rdy;
   logic [31:0] bt, jt;

   logic [31:0] pc_out, pc_out2;
   logic [63:0] pc_hist, pc_hist2;
   logic        pend, pend2, mis, mis2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pc_unit_if #(.XLEN(32)) if0 ();
   pc_unit_if #(.XLEN(32)) if1 ();
   assign if0.imem_req_ready = rdy;
   assign if1.imem_req_ready = rdy;

   pc_unit u_dut (
      .clk(clk), .rst(rst), .stall(stall),
      .branch_taken(br), .branch_target(bt),
      .jump_valid(jv), .jump_target(jt),
      .imem(if0.master),
      .pc_out(pc_out), .pc_hist(pc_hist),
      .redirect_pending(pend), .target_misalign(mis)
   );

   pc_unit #(.RESET_VECTOR(32'hFFFF_FFF8)) u_dut2 (
      .clk(clk), .rst(rst), .stall(stall),
      .branch_taken(br), .branch_target(bt),
      .jump_valid(jv), .jump_target(jt),
      .imem(if1.master),
      .pc_out(pc_out2), .pc_hist(pc_hist2),
      .redirect_pending(pend2), .target_misalign(mis2)
   );

   // ---------------- reference model ----------------
   typedef struct packed {
      logic             started;   // first cycle after reset has passed
      logic             held;      // a raised request is still outstanding
      logic             pend;
      logic [31:0]      ptgt;
      logic [31:0]      pc;
      logic             mis;
      logic [1:0][31:0] hist;
   } mstate_t;

   mstate_t m;

   function automatic logic m_valid(mstate_t s, logic st);
      return s.started && (s.held || !st);
   endfunction

   function automatic mstate_t model_next(mstate_t s, logic st, logic b, logic [31:0] btg,
                                          logic j, logic [31:0] jtg, logic r);
      mstate_t     n = s;
      logic        v, acc, redir;
      logic [31:0] rt;
      n.mis = 1'b0;
      if (!s.started) begin
         n.started = 1'b1;
         return n;
      end
      v     = s.held || !st;
      acc   = v && r;
      redir = b || j;
      rt    = b ? btg : jtg;
      if (!v || acc) begin
         if (redir) begin
            n.pc = rt & 32'hFFFF_FFFC; n.mis = |rt[1:0]; n.pend = 1'b0;
         end else if (s.pend) begin
            n.pc = s.ptgt & 32'hFFFF_FFFC; n.mis = |s.ptgt[1:0]; n.pend = 1'b0;
         end else if (acc) begin
            n.pc = s.pc + 32'd4;
         end
      end else if (redir) begin
         n.pend = 1'b1; n.ptgt = rt;
      end
      n.held = v && !r;
      if (acc) n.hist = {s.hist[0], s.pc};
      return n;
   endfunction

   always @(posedge clk) begin
      if (rst) m <= '0;
      else     m <= model_next(m, stall, br, bt, jv, jt, rdy);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, after inputs have settled.
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         #2;
         chk("valid",   64'(if0.imem_req_valid), 64'(m_valid(m, stall)));
         chk("addr",    64'(if0.imem_req_addr),  64'(m.pc));
         chk("pc_out",  64'(pc_out),             64'(m.pc));
         chk("pc_hist", pc_hist,                 m.hist);
         chk("pending", 64'(pend),               64'(m.pend));
         chk("misal",   64'(mis),                64'(m.mis));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic s, input logic b, input logic [31:0] btg,
                      input logic j, input logic [31:0] jtg, input logic r);
      @(negedge clk);
      #1;
      stall = s; br = b; bt = btg; jv = j; jt = jtg; rdy = r;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; br = 1'b0; jv = 1'b0; bt = '0; jt = '0; rdy = 1'b1;
      repeat (3) @(negedge clk);
      #3;
      chk("rst_pc",    64'(pc_out),             64'h0);
      chk("rst_valid", 64'(if0.imem_req_valid), 64'h0);
      chk("rst_hist",  pc_hist,                 64'h0);
      chk("rst_pend",  64'(pend),               64'h0);
      chk("rst_pc2",   64'(pc_out2),            64'hFFFF_FFF8);

      // A: IDLE cycle after release
      @(negedge clk); #1 rst = 1'b0;
      #1 chk("A_valid", 64'(if0.imem_req_valid), 64'h0);
      // B, C: sequential fetch
      cyc(0, 0, 0, 0, 0, 1);
      #1 chk("B_addr", 64'(if0.imem_req_addr), 64'h0);
      chk("B_valid", 64'(if0.imem_req_valid), 64'h1);
      chk("B_addr2", 64'(if1.imem_req_addr), 64'hFFFF_FFF8);
      cyc(0, 0, 0, 0, 0, 1);
      #1 chk("C_addr", 64'(if0.imem_req_addr), 64'h4);
      chk("C_addr2", 64'(if1.imem_req_addr), 64'hFFFF_FFFC);
      // D: 0x8 held; E: branch while held; F: stall during WAIT
      cyc(0, 0, 0, 0, 0, 0);
      #1 chk("D_addr", 64'(if0.imem_req_addr), 64'h8);
      chk("D_hist", pc_hist, 64'h0000_0000_0000_0004);
      chk("D_addr2", 64'(if1.imem_req_addr), 64'h0);
      cyc(0, 1, 32'h100, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      #1 chk("F_addr", 64'(if0.imem_req_addr), 64'h8);
      chk("F_valid", 64'(if0.imem_req_valid), 64'h1);
      chk("F_pend",  64'(pend), 64'h1);
      // G: accept 0x8; H: target in place, then stall in RUN
      cyc(0, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 1);
      #1 chk("H_addr", 64'(if0.imem_req_addr), 64'h100);
      chk("H_pend",  64'(pend), 64'h0);
      chk("H_valid", 64'(if0.imem_req_valid), 64'h0);
      chk("H_hist",  pc_hist, 64'h0000_0004_0000_0008);
      // I: jump during stall; J: applied while still stalled
      cyc(1, 0, 0, 1, 32'h40, 1);
      #1 chk("I_pc", 64'(pc_out), 64'h100);
      cyc(1, 0, 0, 0, 0, 1);
      #1 chk("J_pc", 64'(pc_out), 64'h40);
      chk("J_valid", 64'(if0.imem_req_valid), 64'h0);
      // K: stall drops, branch + jump together on the handshake
      cyc(0, 1, 32'h200, 1, 32'h300, 1);
      #1 chk("K_valid", 64'(if0.imem_req_valid), 64'h1);
      chk("K_addr", 64'(if0.imem_req_addr), 64'h40);
      // L: branch to misaligned 0x103 on handshake
      cyc(0, 1, 32'h103, 0, 0, 1);
      #1 chk("L_addr", 64'(if0.imem_req_addr), 64'h200);
      chk("L_hist", pc_hist, 64'h0000_0008_0000_0040);
      cyc(0, 0, 0, 0, 0, 1);
      #1 chk("M_addr", 64'(if0.imem_req_addr), 64'h100);
      chk("M_misal", 64'(mis), 64'h1);
      // N..P: hold 0x104, buffer a jump, then reset mid-WAIT
      cyc(0, 0, 0, 0, 0, 0);
      #1 chk("N_addr", 64'(if0.imem_req_addr), 64'h104);
      chk("N_misal", 64'(mis), 64'h0);
      cyc(0, 0, 0, 1, 32'h500, 0);
      cyc(0, 0, 0, 0, 0, 0);
      #1 chk("P_pend", 64'(pend), 64'h1);
      rst = 1'b1;
      cyc(0, 0, 0, 0, 0, 1);
      rst = 1'b0;
      #1 chk("Q_valid", 64'(if0.imem_req_valid), 64'h0);
      chk("Q_pc",   64'(pc_out), 64'h0);
      chk("Q_pend", 64'(pend), 64'h0);
      chk("Q_hist", pc_hist, 64'h0);
      chk("Q_mis",  64'(mis), 64'h0);

      // Mixed traffic, checked by the per-cycle compare.
      for (int i = 0; i < 300; i++) begin
         cyc($urandom_range(3) == 0, $urandom_range(6) == 0, $urandom,
             $urandom_range(6) == 0, $urandom, $urandom_range(9) < 7);
      end

      @(negedge clk);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised fetch-stage program-counter unit, successor to the single-cycle PC register. It issues instruction-fetch addresses over a valid/ready request channel and arbitrates branch and jump redirects with fixed priority. It buffers one redirect that arrives while a request is held, and keeps a configurable-depth history of previously issued fetch addresses for downstream pipeline stages.

## Interface
- XLEN, 32, address width
- RESET_VECTOR, 0, PC value loaded by reset
- STEP, 4, sequential increment in bytes
- HIST_DEPTH, 2, number of previous accepted fetch addresses retained (≥1)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  back-end stall (load waiting on dmem, etc.)
- branch_taken  in  1  branch resolved taken (execute stage)
- branch_target  in  XLEN  branch destination
- jump_valid  in  1  jump decoded (decode stage)
- jump_target  in  XLEN  jump destination
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  XLEN  fetch address, equal to pc_out
- imem_req_ready  in  1  instruction memory accepts request
- pc_out  out  XLEN  current PC register
- pc_hist  out  HIST_DEPTH*XLEN  accepted-address history; slice 0 holds the most recent
- redirect_pending  out  1  a buffered redirect is waiting
- target_misalign  out  1  one-cycle pulse: the applied target had bits [1:0] nonzero

## Operation
- FSM states: IDLE, RUN, WAIT.
  - IDLE: entered on reset; lasts exactly one cycle; then RUN.
  - RUN → WAIT when imem_req_valid=1 and imem_req_ready=0.
  - WAIT → RUN on handshake (valid & ready).
- imem_req_valid:
  - 0 in IDLE.
  - In RUN, it equals !stall.
  - In WAIT, it is 1 regardless of stall. A request that has been raised is never dropped.
- Redirect source: live branch_taken beats live jump_valid (the older instruction wins).
- pc_out update rules, evaluated each cycle:
  - valid=0 (IDLE excluded): if a live redirect is present, pc ← that target; else if pending, pc ← pending target and pending is cleared; else pc holds.
  - Handshake: pc ← live redirect target if present; else pending target if set; else pc+STEP. Pending is cleared in all three cases. The accepted address is shifted into pc_hist.
  - valid=1 & ready=0: pc holds. A live redirect is written into the pending buffer and overwrites any older pending entry.
- Targets are applied with bits [1:0] forced to 0. target_misalign pulses in the cycle after application.
- Arithmetic: pc+STEP is modulo 2^XLEN, so 0xFFFF_FFFC + 4 wraps to 0.
- pc_hist shifts only on handshake: hist[i] ← hist[i-1], hist[0] ← accepted address.

## Timing
- Reset values:
  - pc_out = RESET_VECTOR
  - state = IDLE
  - imem_req_valid = 0
  - pc_hist = all zeros
  - redirect_pending = 0
  - target_misalign = 0
- rst has priority over every input. Reset mid-WAIT drops the request and clears pending in the same edge.
- First request is valid in the second cycle after rst deasserts, with address RESET_VECTOR.
- Redirect latency:
  - When not held: target appears on imem_req_addr the cycle after the redirect.
  - When held: target appears the cycle after the handshake.
- Sustained ready=1 with no stall gives one address per cycle.
- Redirect coincident with handshake: the current address is still accepted (wrong path, flushed downstream). Next address is the target.
- Branch and jump asserted together: the jump is discarded.

## Structure
- Package pc_pkg holds:
  - state enum {IDLE, RUN, WAIT}
  - default constants RESET_VECTOR_DEF and STEP_DEF
  - redirect-source priority encoding
- Sub-module pc_history: parametrised shift register (XLEN, HIST_DEPTH) with a shift-enable input and a synchronous clear.
- Top-level pc_unit contains the FSM, redirect arbiter, pending buffer and PC register.

## Test plan
- Reset release, ready=1, stall=0:
  - addresses 0x0, 0x4, 0x8 on consecutive cycles
  - pc_hist[0]=0x4 after the second accept
- ready=0 for 3 cycles, then branch_taken to 0x100 in the second held cycle:
  - addr holds 0x8 and valid stays 1
  - redirect_pending=1
  - after accept, next addr = 0x100 and pending = 0
- stall=1 in RUN:
  - valid=0, pc holds
  - jump_valid to 0x40 during the stall → pc_out=0x40 next cycle
  - valid returns when stall drops
- branch_taken (0x200) and jump_valid (0x300) in the same cycle as a handshake → next addr 0x200.
- RESET_VECTOR=0xFFFF_FFF8, sequential fetch → 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- Branch target 0x103:
  - applied as 0x100
  - target_misalign pulses for one cycle
- rst asserted in WAIT with pending set → all outputs at reset values next cycle.
